digit_serial_mult: RTL and testbench

//  Multi-cycle WIDTH x WIDTH unsigned multiplier for the RSA datapath, built on the 4x4 digit multiplier.

---
 rtl/rsa_mult_pkg.sv | 16 +
 rtl/shift_add_mult4.sv | 15 +
 rtl/digit_serial_mult.sv | 140 ++++++++++++++
 tb/tb_digit_serial_mult.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_mult_pkg.sv
// Shared types and constants for the RSA digit-serial multiplier datapath.
package rsa_mult_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int unsigned ndigits(input int unsigned width);
      return width / DIGIT_W;
   endfunction

endpackage

// File: rtl/shift_add_mult4.sv
// Combinational 4x4 unsigned digit multiplier built from shifted adds.
module shift_add_mult4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   output logic [7:0] p_o
);

   always_comb begin
      p_o = '0;
      for (int k = 0; k < 4; k++) begin
         if (b_i[k]) p_o = p_o + (8'(a_i) << k);
      end
   end

endmodule

// File: rtl/digit_serial_mult.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier: one 4x4 digit product per cycle,
// accumulated at 2*WIDTH with valid/ready handshakes on both sides.
module digit_serial_mult
   import rsa_mult_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int unsigned ND = ndigits(WIDTH);
   localparam int unsigned CW = (ND > 1) ? $clog2(ND) : 1;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned SW = $clog2(PW);
   localparam logic [CW-1:0] LAST = CW'(ND - 1);

   if ((WIDTH % DIGIT_W) != 0 || WIDTH < 8) begin : g_width_check
      $error("digit_serial_mult: WIDTH must be a multiple of 4 and >= 8");
   end

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [CW-1:0]    i_q, i_d, j_q, j_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [DIGIT_W-1:0]   a_dig, b_dig;
   logic [2*DIGIT_W-1:0] pp;
   logic [SW-1:0]        shamt;
   logic [PW-1:0]        acc_sum;

   // Digit select: i walks a's digits (inner loop), j walks b's digits.
   assign a_dig = DIGIT_W'(a_q >> (DIGIT_W * int'(i_q)));
   assign b_dig = DIGIT_W'(b_q >> (DIGIT_W * int'(j_q)));

   shift_add_mult4 u_mult4 (
      .a_i (a_dig),
      .b_i (b_dig),
      .p_o (pp)
   );

   assign shamt   = SW'(DIGIT_W * (int'(i_q) + int'(j_q)));
   assign acc_sum = acc_q + (PW'(pp) << shamt);

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      i_d         = i_q;
      j_d         = j_q;
      acc_d       = acc_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               a_d        = a;
               b_d        = b;
               acc_d      = '0;
               i_d        = '0;
               j_d        = '0;
               state_d    = RUN;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         RUN: begin
            acc_d = acc_sum;
            if (i_q == LAST) begin
               i_d = '0;
               if (j_q == LAST) begin
                  j_d         = '0;
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end else begin
                  j_d = j_q + CW'(1);
               end
            end else begin
               i_d = i_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         i_q         <= '0;
         j_q         <= '0;
         acc_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         i_q         <= i_d;
         j_q         <= j_d;
         acc_q       <= acc_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign p         = acc_q;

endmodule

// File: tb/tb_digit_serial_mult.sv
// Bench for digit_serial_mult at WIDTH=16, 8 and 32 against a plain a*b reference.
module tb_digit_serial_mult;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  iv, ir, ov, bz;
   logic        out_ready;
   logic [31:0] a_drv, b_drv;
   logic [31:0] p16;
   logic [15:0] p8;
   logic [63:0] p32;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   digit_serial_mult #(.WIDTH(16)) u_dut16 (
      .clk (clk), .rst_n (rst_n), .in_valid (iv[0]), .in_ready (ir[0]),
      .a (a_drv[15:0]), .b (b_drv[15:0]), .out_valid (ov[0]),
      .out_ready (out_ready), .p (p16), .busy (bz[0])
   );

   digit_serial_mult #(.WIDTH(8)) u_dut8 (
      .clk (clk), .rst_n (rst_n), .in_valid (iv[1]), .in_ready (ir[1]),
      .a (a_drv[7:0]), .b (b_drv[7:0]), .out_valid (ov[1]),
      .out_ready (out_ready), .p (p8), .busy (bz[1])
   );

   digit_serial_mult #(.WIDTH(32)) u_dut32 (
      .clk (clk), .rst_n (rst_n), .in_valid (iv[2]), .in_ready (ir[2]),
      .a (a_drv), .b (b_drv), .out_valid (ov[2]),
      .out_ready (out_ready), .p (p32), .busy (bz[2])
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int width_of(input int sel);
      return (sel == 0) ? 16 : (sel == 1) ? 8 : 32;
   endfunction

   function automatic logic [63:0] p_of(input int sel);
      return (sel == 0) ? 64'(p16) : (sel == 1) ? 64'(p8) : p32;
   endfunction

   // Reference: the product of the operands truncated to the instance width.
   function automatic logic [63:0] ref_prod(input int sel, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] mask;
      mask = (64'(1) << width_of(sel)) - 64'(1);
      return (64'(a) & mask) * (64'(b) & mask);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_accept(input int sel, input logic [31:0] a, input logic [31:0] b);
      int w = 0;
      while (ir[sel] !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      check("accept_ready", 64'(ir[sel]), 64'(1));
      a_drv   = a;
      b_drv   = b;
      iv[sel] = 1'b1;
      tick();
      iv[sel] = 1'b0;
      a_drv   = $urandom;
      b_drv   = $urandom;
      check("accepted", 64'(ir[sel]), 64'(0));
   endtask

   task automatic wait_done(input int sel, input logic [63:0] exp, input bit pulses);
      int lat = 0;
      int nd  = width_of(sel) / 4;
      bit bad = 1'b0;
      while (ov[sel] !== 1'b1 && lat < 5000) begin
         if (ir[sel] !== 1'b0 || bz[sel] !== 1'b1) bad = 1'b1;
         if (pulses) begin
            iv[sel] = 1'($urandom_range(0, 1));
            a_drv   = $urandom;
            b_drv   = $urandom;
         end
         tick();
         lat++;
      end
      iv[sel] = 1'b0;
      check("latency", 64'(lat), 64'(nd * nd));
      check("product", p_of(sel), exp);
      check("run_flags", 64'(bad), 64'(0));
   endtask

   task automatic release_job(input int sel, input logic [63:0] exp, input int stall, input bit pulses);
      bit bad = 1'b0;
      for (int k = 0; k < stall; k++) begin
         if (ov[sel] !== 1'b1 || ir[sel] !== 1'b0 || bz[sel] !== 1'b1 || p_of(sel) !== exp) bad = 1'b1;
         if (pulses) begin
            iv[sel] = 1'($urandom_range(0, 1));
            a_drv   = $urandom;
         end
         tick();
      end
      iv[sel] = 1'b0;
      check("stall_hold", 64'(bad), 64'(0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_valid", 64'(ov[sel]), 64'(0));
      check("release_ready", 64'(ir[sel]), 64'(1));
      check("p_kept", p_of(sel), exp);
   endtask

   task automatic run_job(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input bit pulses);
      logic [63:0] exp;
      exp = ref_prod(sel, a, b);
      do_accept(sel, a, b);
      wait_done(sel, exp, pulses);
      release_job(sel, exp, stall, pulses);
   endtask

   initial begin
      logic [63:0] exp;
      bit          bad;
      rst_n     = 1'b1;
      iv        = '0;
      out_ready = 1'b0;
      a_drv     = '0;
      b_drv     = '0;
      #2 rst_n  = 1'b0;
      #1;
      check("rst_in_ready", 64'(ir), 64'(3'b111));
      check("rst_out_valid", 64'(ov), 64'(0));
      check("rst_busy", 64'(bz), 64'(0));
      check("rst_p", p_of(0) | p_of(1) | p_of(2), 64'(0));
      #15 rst_n = 1'b1;

      // out_ready while idle must be ignored
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_out_ready", 64'({ir, ov}), 64'({3'b111, 3'b000}));

      // T1: asynchronous reset in the middle of a run
      do_accept(0, 32'h1234, 32'h5678);
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      check("t1_rst_ready", 64'(ir[0]), 64'(1));
      check("t1_rst_valid", 64'(ov[0]), 64'(0));
      check("t1_rst_p", p_of(0), 64'(0));
      tick();
      #2 rst_n = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (ov[0] !== 1'b0 || p_of(0) !== 64'(0)) bad = 1'b1;
      end
      check("t1_no_valid_after_abort", 64'(bad), 64'(0));
      run_job(0, 32'h1234, 32'h5678, 0, 1'b0);
      check("t1_literal", p_of(0), 64'h0626_0060);

      // T2: maximum operands
      run_job(0, 32'hFFFF, 32'hFFFF, 2, 1'b0);
      check("t2_literal", p_of(0), 64'hFFFE_0001);

      // T3: backpressure with ignored in_valid pulses
      run_job(0, 32'h00FF, 32'h0100, 10, 1'b1);
      check("t3_literal", p_of(0), 64'h0000_FF00);

      // T4: zero operand, then a back-to-back job offered on the release edge
      do_accept(0, 32'h0000, 32'hBEEF);
      wait_done(0, 64'(0), 1'b0);
      a_drv     = 32'h0001;
      b_drv     = 32'hBEEF;
      iv[0]     = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t4_release_no_accept", 64'({ir[0], ov[0]}), 64'(2'b10));
      check("t4_zero_p", p_of(0), 64'(0));
      tick();
      iv[0] = 1'b0;
      check("t4_next_accept", 64'(ir[0]), 64'(0));
      wait_done(0, 64'h0000_BEEF, 1'b0);
      release_job(0, 64'h0000_BEEF, 0, 1'b0);

      // T5: random traffic on every width, with corner operands mixed in
      for (int sel = 0; sel < 3; sel++) begin
         int n_jobs;
         n_jobs = (sel == 0) ? 1500 : (sel == 1) ? 300 : 200;
         for (int n = 0; n < n_jobs; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
               0: ra = '0;
               1: rb = '1;
               2: begin ra = '1; rb = '1; end
               default: ;
            endcase
            repeat ($urandom_range(0, 2)) tick();
            run_job(sel, ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         end
      end

      exp = ref_prod(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_job(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
      check("w32_max", p_of(2), exp);
      run_job(1, 32'h0000_00FF, 32'h0000_00FF, 1, 1'b0);
      check("w8_max", p_of(1), 64'h0000_FE01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
